// File: rtl/memory_arbiter.sv
// Single-port memory arbiter for fetch, load and store requesters.
// Optional bus timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module memory_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        fetch_req,
    input  logic [31:0] fetch_address,
    output logic        fetch_valid,
    output logic [31:0] fetch_data,
    input  logic        flush,
    input  logic        load_req,
    input  logic [31:0] load_address,
    output logic        load_valid,
    output logic [31:0] load_data,
    input  logic        store_req,
    input  logic [31:0] store_address,
    input  logic [31:0] store_data,
    output logic        store_valid,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data,
    input  logic        mem_ready,
    output logic        bus_error
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        STORE
    } state_t;

    state_t state;
    logic   discard;
    logic   busy;
    logic   timed_out;
    logic   done;

    assign busy = (state != IDLE);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [7:0] wait_count;
    logic       bus_error_q;

    assign timed_out = busy && !mem_ready && (wait_count == TIMEOUT_LIMIT);
    assign bus_error = bus_error_q;

    // Count stalled busy cycles; a timeout latches the sticky error
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wait_count  <= '0;
            bus_error_q <= 1'b0;
        end else begin
            if (!busy) begin
                wait_count <= '0;
            end else if (!mem_ready && !timed_out) begin
                wait_count <= wait_count + 8'd1;
            end
            if (timed_out) begin
                bus_error_q <= 1'b1;
            end
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT_CYCLES;

    assign timed_out = 1'b0;
    assign bus_error = 1'b0;
`endif

    assign done = busy && (mem_ready || timed_out);

    assign mem_read_enable  = (state == FETCH) || (state == LOAD);
    assign mem_write_enable = (state == STORE);

    assign fetch_valid = (state == FETCH) && done && !discard && !flush;
    assign load_valid  = (state == LOAD) && done;
    assign store_valid = (state == STORE) && done;

    // A timed-out read returns zero rather than whatever the bus shows
    assign fetch_data = (fetch_valid && !timed_out) ? mem_read_data : '0;
    assign load_data  = (load_valid && !timed_out) ? mem_read_data : '0;

    // Grant in IDLE by fixed priority, hold the owner until completion
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            discard        <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    discard <= 1'b0;
                    if (store_req) begin
                        state          <= STORE;
                        mem_address    <= store_address;
                        mem_write_data <= store_data;
                    end else if (load_req) begin
                        state       <= LOAD;
                        mem_address <= load_address;
                    end else if (fetch_req && !flush) begin
                        state       <= FETCH;
                        mem_address <= fetch_address;
                    end
                end
                default: begin
                    if ((state == FETCH) && flush) begin
                        discard <= 1'b1;
                    end
                    if (done) begin
                        state   <= IDLE;
                        discard <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter.
// Table-driven accesses, a scoreboard monitor and directed corner cases.
module tb_memory_arbiter;

    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_data;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_address = '0;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        flush = 1'b0;
    logic        load_req = 1'b0;
    logic [31:0] load_address = '0;
    logic        load_valid;
    logic [31:0] load_data;
    logic        store_req = 1'b0;
    logic [31:0] store_address = '0;
    logic [31:0] store_data = '0;
    logic        store_valid;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_read_data = '0;
    logic        mem_ready = 1'b0;
    logic        bus_error;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];

    logic [31:0] mem_model [logic [31:0]];
    int  lat = 0;
    bit  hang = 1'b0;
    bit  idle_noise = 1'b0;
    int  busy_cnt = 0;

    memory_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .fetch_req        (fetch_req),
        .fetch_address    (fetch_address),
        .fetch_valid      (fetch_valid),
        .fetch_data       (fetch_data),
        .flush            (flush),
        .load_req         (load_req),
        .load_address     (load_address),
        .load_valid       (load_valid),
        .load_data        (load_data),
        .store_req        (store_req),
        .store_address    (store_address),
        .store_data       (store_data),
        .store_valid      (store_valid),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data),
        .mem_ready        (mem_ready),
        .bus_error        (bus_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return ~a;
    endfunction

    // Memory model: answers after lat busy cycles unless hung
    always @(posedge clock) begin
        #1;
        if (mem_read_enable || mem_write_enable) begin
            mem_ready = !hang && (busy_cnt == lat);
            mem_read_data = (mem_ready && mem_read_enable) ?
                            mem_rd(mem_address) : '0;
            if (mem_ready && mem_write_enable)
                mem_model[mem_address] = mem_write_data;
            busy_cnt = mem_ready ? 0 : busy_cnt + 1;
        end else begin
            mem_ready = idle_noise;
            mem_read_data = idle_noise ? 32'hBAD0BAD0 : '0;
            busy_cnt = 0;
        end
    end

    int          mon_nv;
    logic [1:0]  mon_k;
    logic [31:0] mon_d;
    exp_t        mon_e;

    // Scoreboard monitor: every valid pulse must match the queue head
    always @(negedge clock) begin
        mon_nv = int'(fetch_valid) + int'(load_valid) + int'(store_valid);
        if (mon_nv > 1) begin
            chk("one_valid", 32'(mon_nv), 32'd1);
        end else if (mon_nv == 1) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", {fetch_valid, load_valid, store_valid}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                mon_k = store_valid ? K_STORE : (load_valid ? K_LOAD : K_FETCH);
                mon_d = load_valid ? load_data : fetch_data;
                chk("sb_kind", 32'(mon_k), 32'(mon_e.kind));
                chk("sb_addr", mem_address, mon_e.addr);
                if (mon_k == K_STORE)
                    chk("sb_wdata", mem_write_data, mon_e.wdata);
                else
                    chk("sb_data", mon_d, mon_e.data);
            end
        end
    end

    function automatic logic own_valid(input logic [1:0] k);
        if (k == K_STORE) return store_valid;
        if (k == K_LOAD) return load_valid;
        return fetch_valid;
    endfunction

    task automatic do_access(input vec_t v, input string tag);
        int   n;
        bit   got;
        exp_t e;
        @(posedge clock);
        #1;
        lat = v.lat;
        e.kind = v.kind;
        e.addr = v.addr;
        e.wdata = v.wdata;
        e.data = v.exp_data;
        sb.push_back(e);
        if (v.kind == K_STORE) begin
            store_req = 1'b1;
            store_address = v.addr;
            store_data = v.wdata;
        end else if (v.kind == K_LOAD) begin
            load_req = 1'b1;
            load_address = v.addr;
        end else begin
            fetch_req = 1'b1;
            fetch_address = v.addr;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 50) begin
            @(posedge clock);
            #2;
            n++;
            got = own_valid(v.kind);
            if (!got) begin
                chk({tag, "_addr"}, mem_address, v.addr);
                if (v.kind == K_STORE) begin
                    chk({tag, "_we"}, {mem_write_enable, mem_read_enable}, 32'd2);
                    chk({tag, "_wd"}, mem_write_data, v.wdata);
                end else begin
                    chk({tag, "_re"}, {mem_write_enable, mem_read_enable}, 32'd1);
                end
                chk({tag, "_ld0"}, load_data, 32'd0);
                chk({tag, "_fd0"}, fetch_data, 32'd0);
            end
        end
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_lat"}, 32'(n), 32'(v.lat + 1));
        store_req = 1'b0;
        load_req = 1'b0;
        fetch_req = 1'b0;
    endtask

    vec_t vecs[7];
    int   cs, cl, cf;
    bit   ds, dl, df;
    exp_t e0;

    initial begin
        mem_model[32'h100] = 32'h12345678;
        vecs[0] = '{K_STORE, 32'h40, 32'hCAFEF00D, 1, 32'h0};
        vecs[1] = '{K_LOAD, 32'h100, 32'h0, 2, 32'h12345678};
        vecs[2] = '{K_LOAD, 32'h40, 32'h0, 0, 32'hCAFEF00D};
        vecs[3] = '{K_FETCH, 32'h200, 32'h0, 0, 32'hFFFFFDFF};
        vecs[4] = '{K_STORE, 32'h100, 32'hDEADBEEF, 3, 32'h0};
        vecs[5] = '{K_FETCH, 32'h100, 32'h0, 1, 32'hDEADBEEF};
        vecs[6] = '{K_LOAD, 32'hFFFFFFFC, 32'h0, 0, 32'h00000003};

        #12;
        chk("rst_strobes", {mem_read_enable, mem_write_enable}, 32'd0);
        chk("rst_valids", {fetch_valid, load_valid, store_valid}, 32'd0);
        chk("rst_addr", mem_address, 32'd0);
        chk("rst_wdata", mem_write_data, 32'd0);
        chk("rst_berr", 32'(bus_error), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++)
            do_access(vecs[i], $sformatf("vec%0d", i));

        // mem_ready noise while idle must not produce anything
        @(posedge clock);
        #1;
        idle_noise = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #2;
            chk("noise_strobe", {mem_read_enable, mem_write_enable}, 32'd0);
        end
        idle_noise = 1'b0;

        // Simultaneous requests: store, then load, then fetch
        @(posedge clock);
        #1;
        lat = 0;
        e0 = '{K_STORE, 32'h10, 32'h11112222, 32'h0};
        sb.push_back(e0);
        e0 = '{K_LOAD, 32'h20, 32'h0, 32'hFFFFFFDF};
        sb.push_back(e0);
        e0 = '{K_FETCH, 32'h30, 32'h0, 32'hFFFFFFCF};
        sb.push_back(e0);
        store_req = 1'b1; store_address = 32'h10; store_data = 32'h11112222;
        load_req = 1'b1; load_address = 32'h20;
        fetch_req = 1'b1; fetch_address = 32'h30;
        cs = 0; cl = 0; cf = 0;
        ds = 0; dl = 0; df = 0;
        for (int n = 1; n <= 30 && !(ds && dl && df); n++) begin
            @(posedge clock);
            #2;
            if (store_valid) begin cs = n; ds = 1; store_req = 1'b0; end
            if (load_valid) begin cl = n; dl = 1; load_req = 1'b0; end
            if (fetch_valid) begin cf = n; df = 1; fetch_req = 1'b0; end
        end
        store_req = 1'b0; load_req = 1'b0; fetch_req = 1'b0;
        chk("prio_store_cyc", 32'(cs), 32'd1);
        chk("prio_load_cyc", 32'(cl), 32'd3);
        chk("prio_fetch_cyc", 32'(cf), 32'd5);

        // Flush mid-FETCH: bus completes, no fetch_valid
        @(posedge clock);
        #1;
        lat = 2;
        fetch_req = 1'b1;
        fetch_address = 32'h300;
        @(posedge clock);
        #1;
        flush = 1'b1;
        fetch_req = 1'b0;
        #1;
        chk("fl_valid0", 32'(fetch_valid), 32'd0);
        chk("fl_re0", 32'(mem_read_enable), 32'd1);
        @(posedge clock);
        #1;
        flush = 1'b0;
        #1;
        chk("fl_re1", 32'(mem_read_enable), 32'd1);
        @(posedge clock);
        #2;
        chk("fl_ready", 32'(mem_ready), 32'd1);
        chk("fl_valid2", 32'(fetch_valid), 32'd0);
        @(posedge clock);
        #2;
        chk("fl_idle", 32'(mem_read_enable), 32'd0);
        do_access('{K_FETCH, 32'h300, 32'h0, 0, 32'hFFFFFCFF}, "fl_next");

        // Flush coinciding with mem_ready
        @(posedge clock);
        #1;
        lat = 0;
        fetch_req = 1'b1;
        fetch_address = 32'h304;
        @(posedge clock);
        #1;
        flush = 1'b1;
        fetch_req = 1'b0;
        #1;
        chk("flr_ready", 32'(mem_ready), 32'd1);
        chk("flr_valid", 32'(fetch_valid), 32'd0);
        @(posedge clock);
        #1;
        flush = 1'b0;
        #1;
        chk("flr_idle", 32'(mem_read_enable), 32'd0);

        // Flush in IDLE blocks only the fetch grant
        @(posedge clock);
        #1;
        fetch_req = 1'b1;
        fetch_address = 32'h308;
        flush = 1'b1;
        @(posedge clock);
        #2;
        chk("fli_nogrant", 32'(mem_read_enable), 32'd0);
        fetch_req = 1'b0;
        do_access('{K_LOAD, 32'h44, 32'h0, 0, 32'hFFFFFFBB}, "fli_load");
        flush = 1'b0;

        // Reset during LOAD abandons the access
        @(posedge clock);
        #1;
        hang = 1'b1;
        load_req = 1'b1;
        load_address = 32'h500;
        @(posedge clock);
        #2;
        chk("rl_re", 32'(mem_read_enable), 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        load_req = 1'b0;
        #1;
        chk("rl_re0", 32'(mem_read_enable), 32'd0);
        chk("rl_valid", 32'(load_valid), 32'd0);
        chk("rl_addr", mem_address, 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        hang = 1'b0;
        @(posedge clock);
        #2;
        chk("rl_idle", {mem_read_enable, mem_write_enable}, 32'd0);

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout: mem_ready never arrives
        @(posedge clock);
        #1;
        hang = 1'b1;
        e0 = '{K_LOAD, 32'h600, 32'h0, 32'h0};
        sb.push_back(e0);
        load_req = 1'b1;
        load_address = 32'h600;
        cl = 0;
        for (int n = 1; n <= 20 && cl == 0; n++) begin
            @(posedge clock);
            #2;
            if (load_valid) cl = n;
        end
        load_req = 1'b0;
        chk("to_cyc", 32'(cl), 32'd5);
        hang = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        chk("to_berr", 32'(bus_error), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("to_berr_rst", 32'(bus_error), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
`else
        chk("no_berr", 32'(bus_error), 32'd0);
`endif

        repeat (2) @(posedge clock);
        #2;
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
